running_light_ctrl: RTL and testbench

//   Sequencer for the serial-in running-light shift register. Loads an 8-bit pattern

---
 rtl/running_light_ctrl.sv | 134 +++++++++++++
 tb/tb_running_light_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/running_light_ctrl.sv
// Serial loader for a running-light shift register: shifts a pattern out LSB first
// at a programmable step rate, optionally recirculating it so the display rotates.
module running_light_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             mode_i,
  output logic             step_o,
  output logic             data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] pos_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  logic busy;
  logic step_due;
  logic idx_last;

  // Step timing comes from registers only; stop may still veto the strobe.
  assign busy     = (state_q != ST_IDLE);
  assign step_due = busy && (cnt_q == (div_q - DIV_W'(1)));
  assign idx_last = (idx_q == IDX_LAST);

  assign busy_o = busy;
  assign step_o = step_due && !stop;
  assign data_o = pat_q[idx_q];
  assign pos_o  = idx_q;
  assign done_o = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      div_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    div_d   = div_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          pat_d   = pattern_i;
          div_d   = (div_i == '0) ? DIV_W'(1) : div_i;
          mode_d  = mode_i;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (step_due) begin
          cnt_d = '0;
          if (idx_last) begin
            idx_d   = '0;
            state_d = mode_q ? ST_ROTATE : ST_IDLE;
            done_d  = !mode_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_ROTATE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (step_due) begin
          cnt_d = '0;
          idx_d = idx_last ? '0 : (idx_q + IDX_W'(1));
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_running_light_ctrl.sv
// Bench for running_light_ctrl: an elapsed-cycle model checked every cycle, plus a
// bench-side shift register and step timestamps checked against hand-computed values.
module tb_running_light_ctrl;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  pattern_i = '0;
  logic [23:0] div_i = '0;
  logic        mode_i = 1'b0;
  logic        step_o, data_o, busy_o, done_o;
  logic [2:0]  pos_o;

  int total = 0;
  int bad = 0;

  running_light_ctrl #(.WIDTH(8), .IDX_W(3), .DIV_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pattern_i(pattern_i), .div_i(div_i), .mode_i(mode_i),
    .step_o(step_o), .data_o(data_o), .busy_o(busy_o),
    .done_o(done_o), .pos_o(pos_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycles elapsed since start, step every m_div-th cycle, pos = steps taken mod W.
  logic       m_busy = 1'b0;
  logic       m_mode = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_pat = '0;
  int         m_e = 0;
  int         m_div = 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_mode <= 1'b0; m_done <= 1'b0;
      m_pat <= '0; m_e <= 0; m_div <= 1;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (stop) begin
          m_busy <= 1'b0; m_e <= 0;
        end else if ((m_e % m_div) == (m_div - 1) && !m_mode && (m_e / m_div) == W - 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_e <= 0;
        end else begin
          m_e <= m_e + 1;
        end
      end else if (start && !stop) begin
        m_busy <= 1'b1;
        m_pat  <= pattern_i;
        m_div  <= (div_i == '0) ? 1 : int'(div_i);
        m_mode <= mode_i;
        m_e    <= 0;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int n, p, es;
    n  = m_e / m_div;
    p  = m_busy ? (n % W) : 0;
    es = (m_busy && (m_e % m_div) == (m_div - 1) && !stop) ? 1 : 0;
    chk("model_busy", int'(busy_o), int'(m_busy));
    chk("model_step", int'(step_o), es);
    chk("model_pos",  int'(pos_o), p);
    chk("model_data", int'(data_o), int'(m_pat[p]));
    chk("model_done", int'(done_o), int'(m_done));
  end

  // Bench-side display register plus step/done bookkeeping.
  logic       clr_reg = 1'b1;
  logic [7:0] sreg = '0;
  int cyc = 0, step_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0, start_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_reg) begin
      sreg <= '0; step_cnt <= 0; done_cnt <= 0;
    end else begin
      if (step_o) begin
        sreg <= {data_o, sreg[7:1]};
        step_cnt <= step_cnt + 1;
        if (step_cnt == 0) first_cyc <= cyc;
        last_cyc <= cyc;
      end
      if (done_o) done_cnt <= done_cnt + 1;
      if (start && !stop && !busy_o) start_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    clr_reg = 1'b1; tick(1); clr_reg = 1'b0;
  endtask

  task automatic kick(input logic [7:0] pat, input int dv, input logic md);
    pattern_i = pat; div_i = 24'(dv); mode_i = md; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy_o && k < 500) begin tick(1); k++; end
    chk(nm, int'(busy_o), 0);
  endtask

  task automatic wait_steps(input int n, input string nm);
    int k = 0;
    while (step_cnt < n && k < 200) begin tick(1); k++; end
    chk(nm, (step_cnt >= n) ? 1 : 0, 1);
  endtask

  initial begin
    tick(3);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_step", int'(step_o), 0);
    chk("rst_pos",  int'(pos_o), 0);
    rst = 1'b1;
    #1;
    chk("rel_busy", int'(busy_o), 0);
    chk("rel_done", int'(done_o), 0);
    tick(2);
    clr_reg = 1'b0;

    // one-shot, div 1
    clear_mon();
    kick(8'hA5, 1, 1'b0);
    wait_idle("t1_idle");
    tick(2);
    chk("t1_reg", int'(sreg), 'hA5);
    chk("t1_steps", step_cnt, 8);
    chk("t1_done", done_cnt, 1);
    chk("t1_first", first_cyc - start_cyc, 1);
    chk("t1_span", last_cyc - first_cyc, 7);

    // one-shot, div 4
    clear_mon();
    kick(8'h0F, 4, 1'b0);
    wait_idle("t2_idle");
    tick(2);
    chk("t2_reg", int'(sreg), 'h0F);
    chk("t2_steps", step_cnt, 8);
    chk("t2_first", first_cyc - start_cyc, 4);
    chk("t2_span", last_cyc - first_cyc, 28);
    chk("t2_done", done_cnt, 1);

    // load then rotate
    clear_mon();
    kick(8'h01, 1, 1'b1);
    wait_steps(8, "t3_w8");
    chk("t3_reg8", int'(sreg), 'h01);
    wait_steps(9, "t3_w9");
    chk("t3_reg9", int'(sreg), 'h80);
    wait_steps(10, "t3_w10");
    chk("t3_reg10", int'(sreg), 'h40);
    wait_steps(11, "t3_w11");
    chk("t3_reg11", int'(sreg), 'h20);
    chk("t3_busy", int'(busy_o), 1);
    chk("t3_done", done_cnt, 0);

    // stop in a step cycle, then start+stop together
    stop = 1'b1;
    #1;
    chk("t4_step_veto", int'(step_o), 0);
    tick(1);
    stop = 1'b0;
    chk("t4_busy", int'(busy_o), 0);
    chk("t4_pos", int'(pos_o), 0);
    tick(2);
    chk("t4_done", done_cnt, 0);
    pattern_i = 8'hFF; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("t4_ss_busy", int'(busy_o), 0);
    tick(2);
    chk("t4_ss_busy2", int'(busy_o), 0);

    // div 0 acts as div 1; start during load ignored
    clear_mon();
    kick(8'h3C, 0, 1'b0);
    tick(2);
    kick(8'hFF, 5, 1'b1);
    wait_idle("t5_idle");
    tick(2);
    chk("t5_reg", int'(sreg), 'h3C);
    chk("t5_steps", step_cnt, 8);
    chk("t5_first", first_cyc - start_cyc, 1);
    chk("t5_span", last_cyc - first_cyc, 7);
    chk("t5_done", done_cnt, 1);

    // async reset mid-load at idx 3
    clear_mon();
    kick(8'h55, 2, 1'b0);
    wait_steps(3, "t6_w3");
    chk("t6_pos_pre", int'(pos_o), 3);
    rst = 1'b0;
    #1;
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_step", int'(step_o), 0);
    chk("t6_pos",  int'(pos_o), 0);
    chk("t6_data", int'(data_o), 0);
    chk("t6_done", int'(done_o), 0);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("t6_idle", int'(busy_o), 0);
    chk("t6_steps", step_cnt, 3);
    chk("t6_reg", int'(sreg), 'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
